// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: pipeline-side request/hazard inputs and stage control outputs of pipe_ctrl.
// master = pipeline datapath, slave = pipe_ctrl.
interface pipe_ctrl_if;
  logic        ex_pc_pc_wen;
  logic [31:0] ex_pc_pc_data;
  logic        ex_csr_trap_valid;
  logic [31:0] csr_ex_trap_vector;
  logic        id_ex_mdu_req;
  logic        mdu_done;
  logic        id_ex_is_load;
  logic        id_ex_rd_wen;
  logic [4:0]  id_ex_rd_addr;
  logic [4:0]  if_id_rs1_addr;
  logic [4:0]  if_id_rs2_addr;
  logic        if_id_uses_rs1;
  logic        if_id_uses_rs2;

  logic        pc_stall;
  logic        if_id_stall;
  logic        id_ex_stall;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        pc_redirect_wen;
  logic [31:0] pc_redirect_data;
  logic        trap_commit;
  logic        mdu_start;
  logic        mdu_abort;
  logic        mdu_timeout;

  modport master (
    output ex_pc_pc_wen, ex_pc_pc_data, ex_csr_trap_valid, csr_ex_trap_vector,
           id_ex_mdu_req, mdu_done, id_ex_is_load, id_ex_rd_wen, id_ex_rd_addr,
           if_id_rs1_addr, if_id_rs2_addr, if_id_uses_rs1, if_id_uses_rs2,
    input  pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush,
           pc_redirect_wen, pc_redirect_data, trap_commit, mdu_start, mdu_abort, mdu_timeout
  );

  modport slave (
    input  ex_pc_pc_wen, ex_pc_pc_data, ex_csr_trap_valid, csr_ex_trap_vector,
           id_ex_mdu_req, mdu_done, id_ex_is_load, id_ex_rd_wen, id_ex_rd_addr,
           if_id_rs1_addr, if_id_rs2_addr, if_id_uses_rs1, if_id_uses_rs2,
    output pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush,
           pc_redirect_wen, pc_redirect_data, trap_commit, mdu_start, mdu_abort, mdu_timeout
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush/redirect sequencer for the 5-stage core; outputs are combinational (0-cycle),
// traps redirect one cycle later, MDU ops hold the pipe until done or watchdog. Optional stats: PIPE_CTRL_STATS_EN.
module pipe_ctrl #(
  parameter int MDU_MAX_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
`ifdef PIPE_CTRL_STATS_EN
  ,
  output logic [31:0] stat_stall_cycles,
  output logic [31:0] stat_flush_cnt,
  output logic [31:0] stat_trap_cnt
`endif
);

  typedef enum logic [1:0] {RUN, TRAP_REDIR, MDU_BUSY} state_t;

  state_t             state_q, state_d;
  logic [31:0]        vec_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               timeout_q;

  logic               vec_cap, cnt_clr, cnt_inc, timeout_set;
  logic               load_use;
  logic               pc_stall_c, if_id_stall_c, id_ex_stall_c;
  logic               if_id_flush_c, id_ex_flush_c;
  logic               redir_wen_c, trap_commit_c, mdu_start_c, mdu_abort_c;
  logic [31:0]        redir_data_c;

  assign load_use = bus.id_ex_is_load && bus.id_ex_rd_wen && (bus.id_ex_rd_addr != 5'd0) &&
                    (((bus.id_ex_rd_addr == bus.if_id_rs1_addr) && bus.if_id_uses_rs1) ||
                     ((bus.id_ex_rd_addr == bus.if_id_rs2_addr) && bus.if_id_uses_rs2));

  always_comb begin
    state_d       = state_q;
    vec_cap       = 1'b0;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    timeout_set   = 1'b0;
    pc_stall_c    = 1'b0;
    if_id_stall_c = 1'b0;
    id_ex_stall_c = 1'b0;
    if_id_flush_c = 1'b0;
    id_ex_flush_c = 1'b0;
    redir_wen_c   = 1'b0;
    redir_data_c  = 32'd0;
    trap_commit_c = 1'b0;
    mdu_start_c   = 1'b0;
    mdu_abort_c   = 1'b0;
    // Reset forces every output low and lets the register block return to RUN.
    if (!rst) begin
      case (state_q)
        RUN: begin
          if (bus.ex_csr_trap_valid) begin
            trap_commit_c = 1'b1;
            pc_stall_c    = 1'b1;
            if_id_stall_c = 1'b1;
            id_ex_stall_c = 1'b1;
            vec_cap       = 1'b1;
            state_d       = TRAP_REDIR;
          end else if (bus.ex_pc_pc_wen) begin
            redir_wen_c   = 1'b1;
            redir_data_c  = bus.ex_pc_pc_data;
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
          end else if (bus.id_ex_mdu_req) begin
            mdu_start_c   = 1'b1;
            pc_stall_c    = 1'b1;
            if_id_stall_c = 1'b1;
            id_ex_stall_c = 1'b1;
            cnt_clr       = 1'b1;
            state_d       = MDU_BUSY;
          end else if (load_use) begin
            pc_stall_c    = 1'b1;
            if_id_stall_c = 1'b1;
            id_ex_flush_c = 1'b1;
          end
        end
        TRAP_REDIR: begin
          // EX still holds the trapping instruction; its inputs are ignored here.
          redir_wen_c   = 1'b1;
          redir_data_c  = vec_q;
          if_id_flush_c = 1'b1;
          id_ex_flush_c = 1'b1;
          state_d       = RUN;
        end
        MDU_BUSY: begin
          if (bus.mdu_done) begin
            state_d = RUN;
          end else if (cnt_q == CNT_W'(MDU_MAX_CYCLES)) begin
            mdu_abort_c   = 1'b1;
            timeout_set   = 1'b1;
            id_ex_flush_c = 1'b1;
            state_d       = RUN;
          end else begin
            pc_stall_c    = 1'b1;
            if_id_stall_c = 1'b1;
            id_ex_stall_c = 1'b1;
            cnt_inc       = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      vec_q     <= 32'd0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (vec_cap)
        vec_q <= bus.csr_ex_trap_vector;
      if (cnt_clr)
        cnt_q <= '0;
      else if (cnt_inc)
        cnt_q <= cnt_q + CNT_W'(1);
      if (timeout_set)
        timeout_q <= 1'b1;
    end
  end

  assign bus.pc_stall         = pc_stall_c;
  assign bus.if_id_stall      = if_id_stall_c;
  assign bus.id_ex_stall      = id_ex_stall_c;
  assign bus.if_id_flush      = if_id_flush_c;
  assign bus.id_ex_flush      = id_ex_flush_c;
  assign bus.pc_redirect_wen  = redir_wen_c;
  assign bus.pc_redirect_data = redir_data_c;
  assign bus.trap_commit      = trap_commit_c;
  assign bus.mdu_start        = mdu_start_c;
  assign bus.mdu_abort        = mdu_abort_c;
  assign bus.mdu_timeout      = timeout_q & ~rst;

`ifdef PIPE_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_stall_cycles <= 32'd0;
      stat_flush_cnt    <= 32'd0;
      stat_trap_cnt     <= 32'd0;
    end else begin
      if (pc_stall_c)
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      if (id_ex_flush_c)
        stat_flush_cnt <= stat_flush_cnt + 32'd1;
      if (trap_commit_c)
        stat_trap_cnt <= stat_trap_cnt + 32'd1;
    end
  end
`endif

endmodule
